function_select_debouncer: RTL and testbench

Input stage for the 7-line function-code encoder: it synchronizes and debounces seven raw panel switches, validates that exactly one is active, and drives clean one-hot select lines A..G into the encoder. A one-cycle `changed` pulse flags each committed selection change, and a `lock` input freezes the selection while a downstream operation runs.

---
 rtl/function_select_debouncer.sv | 95 +++++++++
 tb/tb_function_select_debouncer.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/function_select_debouncer.sv
// Seven-switch input stage: two-flop synchronizer, debounce FSM with commit lock,
// and one-hot validation decode feeding the function-code encoder.
module function_select_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sw,
    input  logic       lock,
    output logic       A,
    output logic       B,
    output logic       C,
    output logic       D,
    output logic       E,
    output logic       F,
    output logic       G,
    output logic       valid,
    output logic       err,
    output logic       changed
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SETTLING
    } state_t;

    state_t        state, state_n;
    logic [6:0]    sync1, sync2;
    logic [6:0]    cand, cand_n;
    logic [6:0]    stable, stable_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          changed_q, changed_n;
    logic [6:0]    sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1     <= '0;
            sync2     <= '0;
            cand      <= '0;
            stable    <= '0;
            cnt       <= '0;
            state     <= IDLE;
            changed_q <= 1'b0;
        end else begin
            sync1     <= sw;
            sync2     <= sync1;
            cand      <= cand_n;
            stable    <= stable_n;
            cnt       <= cnt_n;
            state     <= state_n;
            changed_q <= changed_n;
        end
    end

    always_comb begin
        cand_n    = cand;
        stable_n  = stable;
        cnt_n     = cnt;
        state_n   = state;
        changed_n = 1'b0;
        if (sync2 != cand) begin
            cand_n  = sync2;
            cnt_n   = '0;
            state_n = SETTLING;
        end else if (state == SETTLING) begin
            if (cnt < CNT_MAX) begin
                cnt_n = cnt + 1'b1;
            end else if (!lock) begin
                // Counter stays saturated while locked, so release commits at once.
                stable_n  = cand;
                state_n   = IDLE;
                changed_n = (cand != stable);
            end
        end
    end

    always_comb begin
        sel   = '0;
        valid = 1'b0;
        err   = 1'b0;
        if ($countones(stable) == 1) begin
            sel   = stable;
            valid = 1'b1;
        end else if (stable != '0) begin
            err = 1'b1;
        end
    end

    assign {A, B, C, D, E, F, G} = sel;
    assign changed = changed_q;

endmodule

// File: tb/tb_function_select_debouncer.sv
// Randomized and directed bench for function_select_debouncer at DEBOUNCE_CYCLES 4 and 1,
// checked every cycle against a run-length model of the synchronized switch stream.
module tb_function_select_debouncer;

    logic       clk;
    logic       rst;
    logic [6:0] sw;
    logic       lock;

    logic [6:0] sel4, sel1;
    logic       valid4, err4, changed4;
    logic       valid1, err1, changed1;

    int unsigned checks;
    int unsigned passed;

    // Reference model state: shared synchronizer, per-instance run tracking.
    int unsigned dly [2];
    logic [6:0]  m_s1, m_s2, m_last;
    int unsigned m_run [2];
    bit          m_done [2];
    logic [6:0]  m_stable [2];
    bit          m_chg [2];

    function_select_debouncer #(.DEBOUNCE_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .sw(sw), .lock(lock),
        .A(sel4[6]), .B(sel4[5]), .C(sel4[4]), .D(sel4[3]),
        .E(sel4[2]), .F(sel4[1]), .G(sel4[0]),
        .valid(valid4), .err(err4), .changed(changed4)
    );

    function_select_debouncer #(.DEBOUNCE_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .sw(sw), .lock(lock),
        .A(sel1[6]), .B(sel1[5]), .C(sel1[4]), .D(sel1[3]),
        .E(sel1[2]), .F(sel1[1]), .G(sel1[0]),
        .valid(valid1), .err(err1), .changed(changed1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] expect_out(input logic [6:0] st, input bit chg);
        if ($countones(st) == 1) return {st, 1'b1, 1'b0, chg};
        if (st == 7'd0)          return {7'd0, 1'b0, 1'b0, chg};
        return {7'd0, 1'b0, 1'b1, chg};
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_last = '0;
        for (int i = 0; i < 2; i++) begin
            m_run[i] = 1; m_done[i] = 1'b1; m_stable[i] = '0; m_chg[i] = 1'b0;
        end
    endtask

    // Commit once the sample seen at sync2 has persisted for DEBOUNCE_CYCLES+1 edges
    // with lock low, at most once per run of identical samples.
    task automatic model_edge(input logic [6:0] s, input logic lk);
        logic [6:0] smp;
        smp = m_s2;
        for (int i = 0; i < 2; i++) begin
            m_chg[i] = 1'b0;
            if (smp != m_last) begin
                m_run[i] = 1; m_done[i] = 1'b0;
            end else if (m_run[i] < 1000) begin
                m_run[i]++;
            end
            if (!m_done[i] && m_run[i] >= dly[i] + 1 && !lk) begin
                m_chg[i]    = (smp != m_stable[i]);
                m_stable[i] = smp;
                m_done[i]   = 1'b1;
            end
        end
        m_last = smp;
        m_s2   = m_s1;
        m_s1   = s;
    endtask

    task automatic check_all(input string tag);
        logic [9:0] obs, exp;
        for (int i = 0; i < 2; i++) begin
            obs = (i == 0) ? {sel4, valid4, err4, changed4} : {sel1, valid1, err1, changed1};
            exp = expect_out(m_stable[i], m_chg[i]);
            checks++;
            assert (obs === exp) passed++;
            else $error("FAIL %s d=%0d observed=%b expected=%b", tag, dly[i], obs, exp);
        end
    endtask

    task automatic step(input logic [6:0] s, input logic lk, input string tag);
        sw   = s;
        lock = lk;
        @(posedge clk);
        model_edge(s, lk);
        #1;
        check_all(tag);
    endtask

    task automatic hold(input logic [6:0] s, input logic lk, input int unsigned n, input string tag);
        for (int k = 0; k < n; k++) step(s, lk, tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        check_all(tag);
        repeat (2) @(posedge clk);
        #1;
        check_all(tag);
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] cur;
        logic       lk;
        checks = 0;
        passed = 0;
        dly[0] = 4;
        dly[1] = 1;
        sw   = '0;
        lock = 1'b0;
        rst  = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;

        hold(7'b0000001, 1'b0, 10, "first_g");

        for (int k = 0; k < 10; k++) hold((k % 2 == 0) ? 7'b0000000 : 7'b0000001, 1'b0, 2, "bounce");
        hold(7'b0000001, 1'b0, 10, "bounce_settle");

        hold(7'b1000100, 1'b0, 10, "multi_err");
        hold(7'b0000000, 1'b0, 10, "clear_err");

        hold(7'b0000001, 1'b0, 10, "pre_lock");
        hold(7'b0100000, 1'b1, 10, "locked");
        hold(7'b0100000, 1'b0, 4, "unlock");

        hold(7'b0001000, 1'b0, 5, "settling_d");
        do_reset("mid_reset");
        hold(7'b0001000, 1'b0, 10, "after_reset");

        for (int b = 6; b >= 0; b--) begin
            cur = 7'd1 << b;
            hold(cur, 1'b0, 9, "sweep");
        end

        cur = '0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       cur = '0;
                    1, 2:    cur = 7'd1 << $urandom_range(0, 6);
                    default: cur = 7'($urandom);
                endcase
            end
            lk = ($urandom_range(0, 4) == 0);
            step(cur, lk, "random");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $fatal(1, "FAIL timeout observed=running expected=finished");
    end

endmodule
